dmem_ctrl: RTL

Parametrised data-memory block for the ARM-like CPU: word-organised RAM with byte/halfword/word access, little-endian lane steering, sign/zero extension of loads, programmable wait states and a req/ready handshake. It replaces the single-cycle data memory on the core's load/store path. It also reports misaligned and out-of-range accesses as a one-cycle fault instead of silently aliasing.

---
 rtl/dmem_if.sv | 22 ++
 rtl/dmem_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Request/response bus between the core's load/store unit and dmem_ctrl.
interface dmem_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] wd;
  logic        ready;
  logic [31:0] rd;
  logic        fault;

  modport master (
    output req, we, size, sgn, a, wd,
    input  ready, rd, fault
  );

  modport slave (
    input  req, we, size, sgn, a, wd,
    output ready, rd, fault
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Word-organised data memory with byte/half/word lanes, load extension,
// programmable wait states and a one-cycle fault report for bad accesses.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS_L    = 4'(WAIT_STATES);
  localparam logic [31:0] HI_MASK = ~((32'd1 << (AW + 2)) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Misalignment, reserved size and out-of-range address all reject the access.
  function automatic logic is_fault(input logic [1:0] sz, input logic [31:0] addr);
    logic f;
    case (sz)
      2'b00:   f = 1'b0;
      2'b01:   f = addr[0];
      2'b10:   f = (addr[1:0] != 2'b00);
      default: f = 1'b1;
    endcase
    return f | (|(addr & HI_MASK));
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] lane);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic s);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {lane, 3'b000};
    case (sz)
      2'b00:   r = s ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
      2'b01:   r = s ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] wd_q, wd_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        sgn_q, sgn_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;
  logic [31:0] rd_q, rd_d;

  logic          commit_s;
  logic          acc_we_s;
  logic          acc_sgn_s;
  logic [1:0]    acc_size_s;
  logic [31:0]   acc_a_s;
  logic [31:0]   acc_wd_s;
  logic [AW-1:0] idx_s;
  logic          fault_s;
  logic          mem_wr_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic [31:0]   rword_s;

  // With zero wait states the commit shares the accept edge, so use the live bus.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we_s   = bus.we;
      acc_sgn_s  = bus.sgn;
      acc_size_s = bus.size;
      acc_a_s    = bus.a;
      acc_wd_s   = bus.wd;
    end else begin
      acc_we_s   = we_q;
      acc_sgn_s  = sgn_q;
      acc_size_s = size_q;
      acc_a_s    = a_q;
      acc_wd_s   = wd_q;
    end
    idx_s    = acc_a_s[AW+1:2];
    fault_s  = is_fault(acc_size_s, acc_a_s);
    be_s     = store_be(acc_size_s, acc_a_s[1:0]);
    wdata_s  = store_data(acc_size_s, acc_wd_s);
    rword_s  = mem[idx_s];
  end

  // Next-state, capture and response logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    wd_d     = wd_q;
    size_d   = size_q;
    we_d     = we_q;
    sgn_d    = sgn_q;
    commit_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          a_d    = bus.a;
          wd_d   = bus.wd;
          size_d = bus.size;
          we_d   = bus.we;
          sgn_d  = bus.sgn;
          cnt_d  = WS_L;
          if (WS_L == 4'd0) begin
            state_d  = S_RESP;
            commit_s = 1'b1;
          end else begin
            state_d  = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d  = S_RESP;
          commit_s = 1'b1;
        end else begin
          state_d  = S_WAIT;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d  = commit_s;
    fault_d  = commit_s & fault_s;
    mem_wr_s = commit_s & acc_we_s & ~fault_s & ~reset;
    rd_d     = rd_q;
    if (commit_s && fault_s) begin
      rd_d = 32'd0;
    end else if (commit_s && !acc_we_s) begin
      rd_d = load_extend(rword_s, acc_size_s, acc_a_s[1:0], acc_sgn_s);
    end else begin
      rd_d = rd_q;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      wd_q    <= 32'd0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sgn_q   <= sgn_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      rd_q    <= rd_d;
    end
  end

  // Lane-masked array write; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[idx_s][i*8 +: 8] <= wdata_s[i*8 +: 8];
        end
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.fault = fault_q;
  assign bus.rd    = rd_q;

endmodule
